// File: rtl/pacman_pkg.sv
// Shared pacman constants: one-hot direction codes, the debounce state
// encoding and the L>U>R>D priority picker.
package pacman_pkg;

    localparam logic [3:0] DIR_L    = 4'b1000;
    localparam logic [3:0] DIR_U    = 4'b0100;
    localparam logic [3:0] DIR_R    = 4'b0010;
    localparam logic [3:0] DIR_D    = 4'b0001;
    localparam logic [3:0] DIR_NONE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    // Reduce any set of buttons (bit order L,U,R,D) to a single direction.
    function automatic logic [3:0] prio_pick(input logic [3:0] v);
        if (v[3])      return DIR_L;
        else if (v[2]) return DIR_U;
        else if (v[1]) return DIR_R;
        else if (v[0]) return DIR_D;
        else           return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button two-flop synchroniser and debounce FSM. o_rise/o_fall flag the
// cycle in which o_held is about to change, so the selector can act on that edge.
module btn_debounce
    import pacman_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk_50mhz,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_held,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_held;
    logic             w_s;
    logic             w_done;

    assign w_s    = r_sync[1];
    assign w_done = (r_cnt == CNT_MAX);
    assign o_held = r_held;
    assign o_rise = (r_state == PRESS_WAIT)   &&  w_s && w_done;
    assign o_fall = (r_state == RELEASE_WAIT) && !w_s && w_done;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                    end else if (w_done) begin
                        r_state <= PRESSED;
                        r_held  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_s) begin
                        r_state <= PRESSED;
                    end else if (w_done) begin
                        r_state <= IDLE;
                        r_held  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Player-control front end: debounces four buttons and selects one direction,
// newest press wins. Define BTN_STICKY_EN to make btn ignore releases.
module btn_conditioner
    import pacman_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn,
    output logic       btn_press,
    output logic [3:0] btn_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [3:0] w_rise;
    logic [3:0] w_fall;
    logic [3:0] r_btn;
    logic       r_press;

    for (genvar g = 0; g < 4; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk_50mhz(clk_50mhz),
            .rst_n    (rst_n),
            .i_raw    (btn_raw[g]),
            .o_held   (btn_held[g]),
            .o_rise   (w_rise[g]),
            .o_fall   (w_fall[g])
        );
    end

`ifndef BTN_STICKY_EN
    // Held set as it will be after this edge, used to pick a fallback direction.
    logic [3:0] w_held_nxt;
    assign w_held_nxt = (btn_held | w_rise) & ~w_fall;
`endif

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_btn   <= DIR_NONE;
            r_press <= 1'b0;
        end else begin
            r_press <= |w_rise;
            if (|w_rise) begin
                r_btn <= prio_pick(w_rise);
            end
`ifndef BTN_STICKY_EN
            else if (|(r_btn & w_fall)) begin
                r_btn <= prio_pick(w_held_nxt);
            end
`endif
        end
    end

    assign btn       = r_btn;
    assign btn_press = r_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4; expected outputs
// are queued per driven cycle and compared after each clock edge.
module tb_btn_conditioner;

    localparam int N = 4;
`ifdef BTN_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] b;
        logic       p;
        logic [3:0] h;
    } exp_t;

    logic       clk_50mhz = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn;
    logic       btn_press;
    logic [3:0] btn_held;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [3:0] eb;
    logic [3:0] eh;

    btn_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
        .clk_50mhz(clk_50mhz),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn      (btn),
        .btn_press(btn_press),
        .btn_held (btn_held)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    function automatic logic [3:0] sel(input logic [3:0] ns, input logic [3:0] st);
        return STICKY ? st : ns;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        e = q.pop_front();
        checks++;
        assert (btn === e.b) else begin
            errors++;
            $error("FAIL %s btn: got %b exp %b", tag, btn, e.b);
        end
        checks++;
        assert (btn_press === e.p) else begin
            errors++;
            $error("FAIL %s btn_press: got %b exp %b", tag, btn_press, e.p);
        end
        checks++;
        assert (btn_held === e.h) else begin
            errors++;
            $error("FAIL %s btn_held: got %b exp %b", tag, btn_held, e.h);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] raw,
                       input logic [3:0] b, input logic p, input logic [3:0] h);
        btn_raw = raw;
        q.push_back('{b: b, p: p, h: h});
        @(posedge clk_50mhz);
        #1;
        check_out(tag);
    endtask

    // Drive raw from edge 0; outputs hold through edge N+1 and change at N+2,
    // then one more steady cycle proves the strobe is a single cycle.
    task automatic change(input string tag, input logic [3:0] raw,
                          input logic [3:0] nb, input logic np, input logic [3:0] nh);
        for (int i = 0; i < N + 2; i++) cyc(tag, raw, eb, 1'b0, eh);
        eb = nb;
        eh = nh;
        cyc(tag, raw, eb, np, eh);
        cyc(tag, raw, eb, 1'b0, eh);
    endtask

    initial begin
        rst_n   = 1'b0;
        btn_raw = 4'b1111;
        #2;
        q.push_back('{b: 4'b0000, p: 1'b0, h: 4'b0000});
        check_out("reset_noclk");
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        eb = 4'b0000;
        eh = 4'b0000;
        change("reset_release", 4'b1111, 4'b1000, 1'b1, 4'b1111);
        change("release_all", 4'b0000, sel(4'b0000, 4'b1000), 1'b0, 4'b0000);

        change("press_L", 4'b1000, 4'b1000, 1'b1, 4'b1000);
        change("press_R", 4'b1010, 4'b0010, 1'b1, 4'b1010);
        change("release_R", 4'b1000, sel(4'b1000, 4'b0010), 1'b0, 4'b1000);
        change("release_L", 4'b0000, sel(4'b0000, 4'b0010), 1'b0, 4'b0000);

        cyc("bounce", 4'b0100, eb, 1'b0, eh);
        cyc("bounce", 4'b0100, eb, 1'b0, eh);
        cyc("bounce", 4'b0000, eb, 1'b0, eh);
        change("bounce", 4'b0100, 4'b0100, 1'b1, 4'b0100);
        change("release_U", 4'b0000, sel(4'b0000, 4'b0100), 1'b0, 4'b0000);

        change("simul_UD", 4'b0101, 4'b0100, 1'b1, 4'b0101);
        change("simul_relU", 4'b0001, sel(4'b0001, 4'b0100), 1'b0, 4'b0001);
        change("simul_relD", 4'b0000, sel(4'b0000, 4'b0100), 1'b0, 4'b0000);

        change("press_D", 4'b0001, 4'b0001, 1'b1, 4'b0001);
        change("press_U_onD", 4'b0101, 4'b0100, 1'b1, 4'b0101);
        change("rel_nonactive_D", 4'b0100, 4'b0100, 1'b0, 4'b0100);

        // Reset asserted mid-operation with U still held on the pins.
        @(negedge clk_50mhz);
        rst_n = 1'b0;
        #1;
        q.push_back('{b: 4'b0000, p: 1'b0, h: 4'b0000});
        check_out("reset_mid");
        cyc("reset_hold", 4'b0100, 4'b0000, 1'b0, 4'b0000);
        cyc("reset_hold", 4'b0100, 4'b0000, 1'b0, 4'b0000);
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        eb = 4'b0000;
        eh = 4'b0000;
        change("post_reset", 4'b0100, 4'b0100, 1'b1, 4'b0100);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d exp 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
